// File: rtl/aes_pkg.sv
// Shared types, lookups and helpers for the byte-serial AES key schedule.
// Key-size encodings, NK/NR/TOTAL tables, FSM states, xtime and Rcon seed.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD   = 2'b01,
    S_EXPAND = 2'b10,
    S_DONE   = 2'b11
  } ks_state_e;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    logic [3:0] n;
    unique case (kl)
      KL_192:  n = 4'd6;
      KL_256:  n = 4'd8;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return nk_of(kl) + 4'd6;
  endfunction

  function automatic logic [7:0] total_of(input logic [1:0] kl);
    return {nr_of(kl) + 4'd1, 4'b0000};
  endfunction

  function automatic logic len_ok(input logic [1:0] kl,
                                  input logic [2:0] en);
    logic ok;
    unique case (kl)
      KL_128:  ok = en[0];
      KL_192:  ok = en[1];
      KL_256:  ok = en[2];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the key schedule.
// Seeds on load, doubles in GF(2^8) on advance, otherwise holds.
module aes_rcon_gen
  import aes_pkg::*;
#(
  parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_adv,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  // Rcon register: seed, advance by xtime, or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rcon <= RCON_INIT;
    end else if (i_load) begin
      r_rcon <= RCON_INIT;
    end else if (i_adv) begin
      r_rcon <= xtime(r_rcon);
    end
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_keysched_seq.sv
// Sequencer for a byte-serial AES-128/192/256 key-expansion datapath.
// Drives mux selects and Rcon; handshakes key-in and round-key-out bytes.
module aes_keysched_seq
  import aes_pkg::*;
#(
  parameter logic [2:0] KEY_LEN_EN = 3'b111,
  parameter logic [7:0] RCON_INIT  = 8'h01,
  parameter int         CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] key_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       sel_input,
  output logic       sel_sbox,
  output logic       sel_rot,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       last_byte,
  output logic       busy,
  output logic       done,
  output logic       err
);

  ks_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_wmod;
  logic [1:0]       r_klen;
  logic             r_err;

  logic [3:0]       w_nk;
  logic [CNT_W-1:0] w_load_last;
  logic [CNT_W-1:0] w_total_last;
  logic [2:0]       w_wmod_nx;
  logic             w_ok;
  logic             w_load;
  logic             w_exp;
  logic             w_xfer;
  logic             w_wlast;
  logic             w_rot;
  logic             w_sub;
  logic             w_start_ok;
  logic [7:0]       w_rcon;

  assign w_nk         = nk_of(r_klen);
  assign w_load_last  = CNT_W'({w_nk, 2'b00} - 6'd1);
  assign w_total_last = CNT_W'(total_of(r_klen) - 8'd1);
  assign w_ok         = len_ok(key_len, KEY_LEN_EN);
  assign w_start_ok   = (r_state == S_IDLE) && start && w_ok;

  assign w_load  = (r_state == S_LOAD);
  assign w_exp   = (r_state == S_EXPAND);
  assign w_xfer  = (w_load && in_valid && out_ready) ||
                   (w_exp && out_ready);
  assign w_wlast = (r_cnt[1:0] == 2'd3);
  assign w_rot   = (r_wmod == 3'd0);
  assign w_sub   = (w_nk == 4'd8) && (r_wmod == 3'd4);

  assign w_wmod_nx = (r_wmod == w_nk[2:0] - 3'd1) ?
                     3'd0 : r_wmod + 3'd1;

  aes_rcon_gen #(
    .RCON_INIT(RCON_INIT)
  ) u_rcon (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_start_ok),
    .i_adv (w_exp && out_ready && w_rot && w_wlast),
    .o_rcon(w_rcon)
  );

  // Control FSM: accept start, count key bytes, then expanded bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wmod  <= 3'd0;
      r_klen  <= KL_128;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_ok) begin
              r_state <= S_LOAD;
              r_cnt   <= '0;
              r_wmod  <= 3'd0;
              r_klen  <= key_len;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_wlast) r_wmod <= w_wmod_nx;
            if (r_cnt == w_load_last) r_state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_wlast) r_wmod <= w_wmod_nx;
            if (r_cnt == w_total_last) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_load && out_ready;
  assign out_valid = (w_load && in_valid) || w_exp;
  assign sel_input = w_exp;
  assign sel_rot   = w_exp && w_rot;
  assign sel_sbox  = w_exp && (w_rot || w_sub);
  assign rcon      = (w_exp && w_rot && r_cnt[1:0] == 2'd0) ?
                     w_rcon : 8'h00;
  assign round     = r_cnt[7:4];
  assign last_byte = w_exp && (r_cnt == w_total_last);
  assign busy      = w_load || w_exp;
  assign done      = (r_state == S_DONE);
  assign err       = r_err;

endmodule

// File: tb/tb_aes_keysched_seq.sv
// Randomised bench for aes_keysched_seq against a per-byte reference model.
// Covers all key sizes, backpressure, rejected sizes and async reset.
module tb_aes_keysched_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [1:0] key_len;
  logic       in_valid, out_ready;

  logic       in_ready, out_valid, sel_input, sel_sbox, sel_rot;
  logic [7:0] rcon;
  logic [3:0] round;
  logic       last_byte, busy, done, err;

  logic       in_ready1, out_valid1, sel_input1, sel_sbox1, sel_rot1;
  logic [7:0] rcon1;
  logic [3:0] round1;
  logic       last_byte1, busy1, done1, err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_keysched_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid),
    .sel_input(sel_input), .sel_sbox(sel_sbox), .sel_rot(sel_rot),
    .rcon(rcon), .round(round), .last_byte(last_byte),
    .busy(busy), .done(done), .err(err)
  );

  aes_keysched_seq #(.KEY_LEN_EN(3'b001)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_len(key_len),
    .in_valid(in_valid), .in_ready(in_ready1),
    .out_ready(out_ready), .out_valid(out_valid1),
    .sel_input(sel_input1), .sel_sbox(sel_sbox1), .sel_rot(sel_rot1),
    .rcon(rcon1), .round(round1), .last_byte(last_byte1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] all0();
    return {in_ready, out_valid, sel_input, sel_sbox, sel_rot,
            rcon, round, last_byte, busy, done, err};
  endfunction

  function automatic logic [20:0] all1();
    return {in_ready1, out_valid1, sel_input1, sel_sbox1, sel_rot1,
            rcon1, round1, last_byte1, busy1, done1, err1};
  endfunction

  // Spec-level model: control bundle expected for expanded byte b.
  function automatic logic [16:0] model(input int kl, input int b);
    logic [7:0] rtab [10];
    int nk, total, w, ph;
    bit ex, rot, sub;
    logic [7:0] rc;
    rtab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    nk    = (kl == 0) ? 4 : (kl == 1) ? 6 : 8;
    total = 16 * (nk + 7);
    w     = b / 4;
    ph    = b % 4;
    ex    = (w >= nk);
    rot   = ex && (w % nk == 0);
    sub   = ex && (nk == 8) && (w % nk == 4);
    rc    = (rot && ph == 0) ? rtab[w / nk - 1] : 8'h00;
    return {ex, rot || sub, rot, rc, 4'(b / 16),
            (b == total - 1), 1'b1};
  endfunction

  task automatic run(input int kl, input bit stall, input int abort_at);
    int nk, total, b, cyc, nrot;
    int exp_nrot [3];
    logic [7:0] exp_last [3];
    logic [7:0] lastrc;
    bit ld, xfer;
    exp_nrot = '{10, 8, 7};
    exp_last = '{8'h36, 8'h80, 8'h40};
    nk    = (kl == 0) ? 4 : (kl == 1) ? 6 : 8;
    total = 16 * (nk + 7);
    @(negedge clk);
    start = 1'b1; key_len = 2'(kl); in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    b = 0; cyc = 0; nrot = 0; lastrc = 8'h00;
    while (b < total && cyc < 4 * total + 50) begin
      if (cyc > 0) @(negedge clk);
      in_valid  = stall ? 1'($urandom % 2) : 1'b1;
      out_ready = stall ? 1'($urandom % 2) : 1'b1;
      start     = 1'($urandom % 2);
      key_len   = 2'($urandom % 4);
      #1;
      if (b == abort_at) begin
        rst = 1'b0;
        #1 chk("async_rst", 32'(all0()), 32'd0);
        @(negedge clk);
        chk("rst_hold", 32'(all0()), 32'd0);
        rst = 1'b1; start = 1'b0;
        return;
      end
      ld = (b < 4 * nk);
      chk("out_valid", 32'(out_valid), 32'(ld ? in_valid : 1'b1));
      chk("in_ready", 32'(in_ready), 32'(ld ? out_ready : 1'b0));
      chk("ctl", 32'({sel_input, sel_sbox, sel_rot, rcon, round,
                      last_byte, busy}), 32'(model(kl, b)));
      xfer = ld ? (in_valid && out_ready) : out_ready;
      if (xfer) begin
        if (rcon != 8'h00) begin
          nrot++;
          lastrc = rcon;
        end
        b++;
      end
      cyc++;
    end
    chk("bytes", 32'(b), 32'(total));
    if (!stall) chk("latency", 32'(cyc), 32'(total));
    chk("nrot", 32'(nrot), 32'(exp_nrot[kl]));
    chk("last_rcon", 32'(lastrc), 32'(exp_last[kl]));
    @(negedge clk);
    start = 1'b1; key_len = 2'b00; in_valid = 1'b0;
    #1 chk("done", 32'({done, busy}), 32'd2);
    @(negedge clk);
    start = 1'b0;
    #1 chk("after_done", 32'({done, busy}), 32'd0);
  endtask

  task automatic err_test(input bit second, input logic [1:0] kl);
    int e, bz;
    @(negedge clk);
    if (second) start1 = 1'b1; else start = 1'b1;
    key_len = kl;
    #1;
    e  = second ? int'(err1) : int'(err);
    bz = second ? int'(busy1) : int'(busy);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0; start1 = 1'b0;
      #1;
      e  += second ? int'(err1) : int'(err);
      bz += second ? int'(busy1) : int'(busy);
    end
    chk(second ? "err_masked" : "err_11", 32'(e), 32'd1);
    chk(second ? "busy_masked" : "busy_11", 32'(bz), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start1 = 1'b0; key_len = 2'b00;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset0", 32'(all0()), 32'd0);
    chk("reset1", 32'(all1()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(0, 1'b0, -1);
    run(1, 1'b0, -1);
    run(2, 1'b0, -1);
    run(0, 1'b1, -1);
    run(1, 1'b1, -1);
    run(2, 1'b1, -1);
    err_test(1'b0, 2'b11);
    err_test(1'b1, 2'b01);
    err_test(1'b1, 2'b10);
    run(0, 1'b0, 100);
    chk("post_rst", 32'(all0()), 32'd0);
    run(0, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
